// File: rtl/modbus_pkg.sv
// Shared types and constants for the Modbus RTU poll scheduler.
package modbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_SEND,
    ST_WAIT_TX,
    ST_WAIT_RX,
    ST_NEXT
  } poll_state_t;

  localparam logic [7:0] MB_FC_READ_HOLDING = 8'h03;
  localparam int         MB_MAX_SLAVE_ID    = 247;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/poll_timer.sv
// Loadable down-counter shared by the inter-frame gap and the response timeout.
module poll_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  // Saturates at zero so expired stays asserted until the next load.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/modbus_poll_scheduler.sv
// Round-robin Modbus RTU read-holding-registers poller with per-slave online map.
// Optional retry support is built when POLL_RETRY_EN is defined.
module modbus_poll_scheduler
  import modbus_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int FIRST_SLAVE_ID = 1,
  parameter int START_REG      = 340,
  parameter int NUM_REGS       = 10,
  parameter int GAP_CYCLES     = 1750,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRIES    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  tx_busy,
  input  logic                  rx_done,
  input  logic                  rx_crc_ok,
  input  logic [7:0]            rx_slave_id,
  output logic                  tx_start,
  output logic [7:0]            tx_slave_id,
  output logic [7:0]            tx_func,
  output logic [15:0]           tx_start_reg,
  output logic [15:0]           tx_reg_count,
  output logic [NUM_SLAVES-1:0] slave_online,
  output logic                  err_strb,
  output logic                  cycle_done,
  output logic                  busy
);

  localparam int IW = cnt_width(NUM_SLAVES);
  localparam int GW = cnt_width(GAP_CYCLES);
  localparam int RXW = cnt_width(TIMEOUT_CYCLES);
  localparam int TW = (GW > RXW) ? GW : RXW;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SLAVES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] RX_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    FIRST_ID = 8'(FIRST_SLAVE_ID);

  poll_state_t           state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [7:0]            tx_slave_id_q, tx_slave_id_d;
  logic [NUM_SLAVES-1:0] online_q, online_d;
  logic                  tx_start_q, tx_start_d;
  logic                  err_q, err_d;
  logic                  cycle_done_q, cycle_done_d;
  logic                  busy_q, busy_d;

  logic                  timer_load;
  logic [TW-1:0]         timer_value;
  logic                  timer_expired;
  logic                  rsp_ok;
  logic                  give_up;

`ifdef POLL_RETRY_EN
  localparam int RW = cnt_width(MAX_RETRIES + 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

  logic [RW-1:0] retry_q, retry_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`else
  logic unused_max_retries;
  assign unused_max_retries = (MAX_RETRIES != 0);
`endif

  poll_timer #(
    .W(TW)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (timer_load),
    .value  (timer_value),
    .expired(timer_expired)
  );

  // Only a CRC-clean frame from the slave currently addressed counts.
  assign rsp_ok = rx_done && rx_crc_ok && (rx_slave_id == tx_slave_id_q);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    online_d     = online_q;
    tx_start_d   = 1'b0;
    err_d        = 1'b0;
    cycle_done_d = 1'b0;
    timer_load   = 1'b0;
    timer_value  = GAP_LOAD;
    give_up      = 1'b0;
`ifdef POLL_RETRY_EN
    retry_d      = retry_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d    = ST_GAP;
          timer_load = 1'b1;
        end
      end
      ST_GAP: begin
        if (timer_expired) begin
          state_d    = ST_SEND;
          tx_start_d = 1'b1;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (!tx_busy) begin
          state_d     = ST_WAIT_RX;
          timer_load  = 1'b1;
          timer_value = RX_LOAD;
        end
      end
      ST_WAIT_RX: begin
        // A response arriving on the last timeout cycle still counts.
        if (rsp_ok) begin
          online_d[idx_q] = 1'b1;
          state_d         = ST_NEXT;
`ifdef POLL_RETRY_EN
          retry_d         = '0;
`endif
        end else if (timer_expired) begin
`ifdef POLL_RETRY_EN
          if (retry_q < RETRY_LIMIT) begin
            retry_d    = retry_q + RW'(1);
            state_d    = ST_GAP;
            timer_load = 1'b1;
          end else begin
            retry_d = '0;
            give_up = 1'b1;
          end
`else
          give_up = 1'b1;
`endif
        end
        if (give_up) begin
          online_d[idx_q] = 1'b0;
          err_d           = 1'b1;
          state_d         = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (idx_q == LAST_IDX) begin
          idx_d        = '0;
          cycle_done_d = 1'b1;
          if (enable) begin
            state_d    = ST_GAP;
            timer_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (!enable) begin
          // Stop mid-round; the next enable re-polls the same slave.
          state_d = ST_IDLE;
        end else begin
          idx_d      = idx_q + IW'(1);
          state_d    = ST_GAP;
          timer_load = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    tx_slave_id_d = FIRST_ID + 8'(idx_d);
    busy_d        = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      tx_slave_id_q <= FIRST_ID;
      online_q      <= '0;
      tx_start_q    <= 1'b0;
      err_q         <= 1'b0;
      cycle_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      tx_slave_id_q <= tx_slave_id_d;
      online_q      <= online_d;
      tx_start_q    <= tx_start_d;
      err_q         <= err_d;
      cycle_done_q  <= cycle_done_d;
      busy_q        <= busy_d;
    end
  end

  assign tx_start     = tx_start_q;
  assign tx_slave_id  = tx_slave_id_q;
  assign tx_func      = MB_FC_READ_HOLDING;
  assign tx_start_reg = 16'(START_REG);
  assign tx_reg_count = 16'(NUM_REGS);
  assign slave_online = online_q;
  assign err_strb     = err_q;
  assign cycle_done   = cycle_done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_modbus_poll_scheduler.sv
// Scoreboard bench for modbus_poll_scheduler: a framer/slave model answers polls,
// expected events are queued by the stimulus and checked by a separate monitor.
module tb_modbus_poll_scheduler;

  localparam int NS  = 3;
  localparam int G   = 4;
  localparam int T   = 20;
  localparam int MR  = 1;
  localparam int TXB = 3;   // framer holds tx_busy for TXB negedges after tx_start

  // Derived spacings between events (in cycles) for this framer model.
  localparam int RETRY_GAP = T + G + TXB + 1;   // tx_start to tx_start after a timeout
  localparam int ERR_GAP   = TXB + 1 + T;       // tx_start to err_strb
  localparam int ADV_GAP   = ERR_GAP + 5;       // tx_start before a failure to next tx_start

  logic        clk = 1'b0;
  logic        reset, enable, tx_busy, rx_done, rx_crc_ok;
  logic [7:0]  rx_slave_id;
  logic        tx_start, err_strb, cycle_done, busy;
  logic [7:0]  tx_slave_id, tx_func;
  logic [15:0] tx_start_reg, tx_reg_count;
  logic [NS-1:0] slave_online;

  modbus_poll_scheduler #(
    .NUM_SLAVES(NS), .FIRST_SLAVE_ID(1), .START_REG(340), .NUM_REGS(10),
    .GAP_CYCLES(G), .TIMEOUT_CYCLES(T), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .tx_busy(tx_busy),
    .rx_done(rx_done), .rx_crc_ok(rx_crc_ok), .rx_slave_id(rx_slave_id),
    .tx_start(tx_start), .tx_slave_id(tx_slave_id), .tx_func(tx_func),
    .tx_start_reg(tx_start_reg), .tx_reg_count(tx_reg_count),
    .slave_online(slave_online), .err_strb(err_strb), .cycle_done(cycle_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_TX, EV_ERR, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       id;
    int       online;
    int       gap;   // cycles since previous tx_start, -1 = unchecked
    int       at;    // absolute cycle, -1 = unchecked
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  last_tx  = 0;

  // Slave behaviour per id: 0 answer at dly, 1 silent, 2 wrong address, 3 bad CRC then good
  int mode [4];
  int dly  [4];
  int dly2 [4];

  function automatic void chk(string nm, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void push(ev_kind_t k, int id, int online, int gap, int at);
    ev_t e;
    e.kind = k; e.id = id; e.online = online; e.gap = gap; e.at = at;
    sb.push_back(e);
  endfunction

  task automatic handle(ev_kind_t k);
    ev_t e;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL unexpected_event: got kind %0d id %0d, required none", k, tx_slave_id);
      return;
    end
    e = sb.pop_front();
    chk("event_kind", k, e.kind);
    case (k)
      EV_TX: begin
        chk("tx_id", tx_slave_id, e.id);
        if (e.gap >= 0) chk("tx_gap", cyc - last_tx, e.gap);
        if (e.at >= 0)  chk("tx_at", cyc, e.at);
        last_tx = cyc;
      end
      EV_ERR: begin
        chk("err_id", tx_slave_id, e.id);
        chk("err_online", slave_online, e.online);
        if (e.gap >= 0) chk("err_gap", cyc - last_tx, e.gap);
      end
      default: begin
        chk("done_online", slave_online, e.online);
      end
    endcase
  endtask

  // Monitor
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (tx_start === 1'b1)   handle(EV_TX);
      if (err_strb === 1'b1)   handle(EV_ERR);
      if (cycle_done === 1'b1) handle(EV_DONE);
    end
  end

  task automatic pulse_rx(int d, logic crc, logic [7:0] sid);
    repeat (d) @(negedge clk);
    rx_done = 1'b1; rx_crc_ok = crc; rx_slave_id = sid;
    @(negedge clk);
    rx_done = 1'b0; rx_crc_ok = 1'b0; rx_slave_id = 8'h00;
  endtask

  // Framer + slave model
  initial begin
    int id;
    tx_busy = 1'b0; rx_done = 1'b0; rx_crc_ok = 1'b0; rx_slave_id = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        id = int'(tx_slave_id) & 3;
        tx_busy = 1'b1;
        repeat (TXB) @(negedge clk);
        tx_busy = 1'b0;
        case (mode[id])
          0: pulse_rx(dly[id], 1'b1, 8'(id));
          2: pulse_rx(dly[id], 1'b1, 8'd5);
          3: begin
            pulse_rx(dly[id], 1'b0, 8'(id));
            pulse_rx(dly2[id] - dly[id] - 1, 1'b1, 8'(id));
          end
          default: ;
        endcase
      end
    end
  end

  task automatic wait_q(int n, int budget);
    int k = 0;
    while (sb.size() > n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() > n) begin
      n_checks++; n_fail++;
      $display("FAIL wait_events: %0d pending, required <= %0d", sb.size(), n);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    enable = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_modes(int m1, int m2, int m3);
    mode[1] = m1; mode[2] = m2; mode[3] = m3;
    for (int i = 0; i < 4; i++) begin
      dly[i] = 5; dly2[i] = 8;
    end
  endtask

  task automatic end_round();
    int k = 0;
    wait_q(1, 3000);
    enable = 1'b0;
    wait_q(0, 3000);
    while (busy !== 1'b0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("idle_after_round", busy, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0;
    set_modes(0, 0, 0);
    #1;
    chk("rst_tx_start", tx_start, 0);
    chk("rst_err", err_strb, 0);
    chk("rst_cycle_done", cycle_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_online", slave_online, 0);
    chk("rst_id", tx_slave_id, 1);
    chk("rst_func", tx_func, 8'h03);
    chk("rst_start_reg", tx_start_reg, 340);
    chk("rst_reg_count", tx_reg_count, 10);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // All slaves answer, two rounds; first tx_start G+1 cycles after enable
    set_modes(0, 0, 0);
    enable = 1'b1;
    push(EV_TX, 1, 0, -1, cyc + G + 1);
    for (int r = 0; r < 2; r++) begin
      push(EV_TX, 2, 0, TXB + 5 + G + 2, -1);
      push(EV_TX, 3, 0, TXB + 5 + G + 2, -1);
      push(EV_DONE, 0, 3'b111, -1, -1);
      if (r == 0) push(EV_TX, 1, 0, -1, -1);
    end
    end_round();

    // Slave 2 silent
    do_reset();
    set_modes(0, 1, 0);
    enable = 1'b1;
    push(EV_TX, 1, 0, -1, -1);
    push(EV_TX, 2, 0, -1, -1);
`ifdef POLL_RETRY_EN
    push(EV_TX, 2, 0, RETRY_GAP, -1);
`endif
    push(EV_ERR, 2, 3'b001, ERR_GAP, -1);
    push(EV_TX, 3, 0, ADV_GAP, -1);
    push(EV_DONE, 0, 3'b101, -1, -1);
    end_round();

    // Wrong-address response to slave 1 is ignored; timeout still at T cycles
    do_reset();
    set_modes(2, 0, 0);
    enable = 1'b1;
    push(EV_TX, 1, 0, -1, -1);
`ifdef POLL_RETRY_EN
    push(EV_TX, 1, 0, RETRY_GAP, -1);
`endif
    push(EV_ERR, 1, 3'b000, ERR_GAP, -1);
    push(EV_TX, 2, 0, ADV_GAP, -1);
    push(EV_TX, 3, 0, TXB + 5 + G + 2, -1);
    push(EV_DONE, 0, 3'b110, -1, -1);
    end_round();

    // Bad CRC then good response: success, no retry
    do_reset();
    set_modes(3, 0, 0);
    enable = 1'b1;
    push(EV_TX, 1, 0, -1, -1);
    push(EV_TX, 2, 0, TXB + 8 + G + 2, -1);
    push(EV_TX, 3, 0, TXB + 5 + G + 2, -1);
    push(EV_DONE, 0, 3'b111, -1, -1);
    end_round();

    // Response on the last timeout cycle wins
    do_reset();
    set_modes(0, 0, 0);
    dly[1] = T;
    enable = 1'b1;
    push(EV_TX, 1, 0, -1, -1);
    push(EV_TX, 2, 0, TXB + T + G + 2, -1);
    push(EV_TX, 3, 0, TXB + 5 + G + 2, -1);
    push(EV_DONE, 0, 3'b111, -1, -1);
    end_round();

    // Reset in WAIT_RX: immediate return to reset values, no further tx_start
    mode[1] = 1;
    enable = 1'b1;
    push(EV_TX, 1, 0, -1, -1);
    wait_q(0, 200);
    repeat (TXB + 6) @(negedge clk);
    chk("busy_in_wait_rx", busy, 1);
    chk("online_before_reset", slave_online, 3'b111);
    reset = 1'b1;
    enable = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_online", slave_online, 0);
    chk("async_rst_id", tx_slave_id, 1);
    chk("async_rst_tx_start", tx_start, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("idle_after_reset", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
